// File: rtl/fp12_leaf_price_gen.sv
// Binomial-tree leaf price generator, unsigned 12-bit fixed point (INT_LEN.FRAC).
// Optional call-payoff output stage enabled by defining FP12_LEAF_PAYOFF_EN.
module fp12_leaf_price_gen #(
  parameter int INT_LEN     = 8,
  parameter int N_MAX_STEPS = 64,
  parameter int STEP_W      = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [11:0]       s0,
  input  logic [11:0]       dn_fac,
  input  logic [11:0]       ud_ratio,
  input  logic [STEP_W-1:0] steps,
  input  logic [11:0]       strike,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [11:0]       out_data,
  output logic [STEP_W-1:0] out_idx,
  output logic              out_last,
  output logic              done,
  output logic              ovf
);

  localparam int                FRAC = 12 - INT_LEN;
  localparam logic [STEP_W-1:0] NMAX = STEP_W'(N_MAX_STEPS);
  localparam logic [STEP_W-1:0] ONE  = STEP_W'(1);

  typedef enum logic [1:0] {IDLE, DPOW, EMIT, DONE} state_t;

  state_t            state_q, state_d;
  logic [11:0]       acc_q, acc_d;
  logic [11:0]       dn_q, dn_d;
  logic [11:0]       ud_q, ud_d;
  logic [11:0]       strike_q, strike_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic [STEP_W-1:0] cnt_q, cnt_d;
  logic [STEP_W-1:0] idx_q, idx_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;

  logic [STEP_W-1:0] steps_clamped;
  logic [11:0]       mul_b;
  logic [23:0]       prod;
  logic [11:0]       mul_res;
  logic              mul_ovf;

  assign steps_clamped = (steps > NMAX) ? NMAX : steps;

  // One shared multiplier: down factor while powering, u/d ratio while emitting.
  assign mul_b   = (state_q == DPOW) ? dn_q : ud_q;
  assign prod    = {12'd0, acc_q} * {12'd0, mul_b};
  assign mul_res = prod[FRAC +: 12];
  assign mul_ovf = |(prod >> (FRAC + 12));

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    dn_d     = dn_q;
    ud_d     = ud_q;
    strike_d = strike_q;
    steps_d  = steps_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    valid_d  = valid_q;
    last_d   = last_q;
    done_d   = 1'b0;
    ovf_d    = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          dn_d     = dn_fac;
          ud_d     = ud_ratio;
          strike_d = strike;
          steps_d  = steps_clamped;
          acc_d    = s0;
          cnt_d    = steps_clamped;
          idx_d    = '0;
          ovf_d    = 1'b0;
          if (steps_clamped != '0) begin
            state_d = DPOW;
          end else begin
            state_d = EMIT;
            valid_d = 1'b1;
            last_d  = 1'b1;
          end
        end
      end
      DPOW: begin
        acc_d = mul_res;
        cnt_d = cnt_q - ONE;
        ovf_d = ovf_q | mul_ovf;
        if (cnt_q == ONE) begin
          state_d = EMIT;
          valid_d = 1'b1;
          last_d  = 1'b0;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (idx_q == steps_q) begin
            state_d = DONE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            acc_d  = mul_res;
            idx_d  = idx_q + ONE;
            last_d = ((idx_q + ONE) == steps_q);
            ovf_d  = ovf_q | mul_ovf;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      dn_q     <= '0;
      ud_q     <= '0;
      strike_q <= '0;
      steps_q  <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      dn_q     <= dn_d;
      ud_q     <= ud_d;
      strike_q <= strike_d;
      steps_q  <= steps_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign out_valid = valid_q;
  assign out_idx   = idx_q;
  assign out_last  = last_q;
  assign done      = done_q;
  assign ovf       = ovf_q;

`ifdef FP12_LEAF_PAYOFF_EN
  assign out_data = (acc_q > strike_q) ? (acc_q - strike_q) : 12'd0;
`else
  logic unused_strike;
  assign unused_strike = ^strike_q;
  assign out_data      = acc_q;
`endif

endmodule

// File: tb/tb_fp12_leaf_price_gen.sv
// Randomized self-checking bench for fp12_leaf_price_gen against an arithmetic leaf model.
module tb_fp12_leaf_price_gen;

  logic        clk, rst_n, start;
  logic [11:0] s0, dn_fac, ud_ratio, strike;
  logic [6:0]  steps;
  logic        busy, out_valid, out_ready, out_last, done, ovf;
  logic [11:0] out_data;
  logic [6:0]  out_idx;

  int n_tests = 0;
  int n_fail  = 0;

  int          exp_leaf [0:64];
  int          exp_n;
  bit          exp_ovf;
  logic [11:0] rx [0:64];

  fp12_leaf_price_gen dut (
    .clk(clk), .rst_n(rst_n), .start(start), .s0(s0), .dn_fac(dn_fac),
    .ud_ratio(ud_ratio), .steps(steps), .strike(strike), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .done(done), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // 8.4 truncating multiply: product / 16, keep 12 bits; anything >= 2^16 overflows.
  function automatic int fx_mul(input int a, input int b);
    return ((a * b) / 16) % 4096;
  endfunction

  function automatic bit fx_ovf(input int a, input int b);
    return (a * b) >= 65536;
  endfunction

  function automatic int payoff(input int acc, input int k);
`ifdef FP12_LEAF_PAYOFF_EN
    return (acc > k) ? acc - k : 0;
`else
    return acc + 0 * k;
`endif
  endfunction

  task automatic build_model(input int a_s0, input int a_dn, input int a_ud, input int a_steps);
    int acc;
    exp_n   = (a_steps > 64) ? 64 : a_steps;
    exp_ovf = 1'b0;
    acc     = a_s0;
    for (int i = 0; i < exp_n; i++) begin
      exp_ovf = exp_ovf | fx_ovf(acc, a_dn);
      acc     = fx_mul(acc, a_dn);
    end
    exp_leaf[0] = acc;
    for (int j = 1; j <= exp_n; j++) begin
      exp_ovf     = exp_ovf | fx_ovf(acc, a_ud);
      acc         = fx_mul(acc, a_ud);
      exp_leaf[j] = acc;
    end
  endtask

  // mode 0: ready always high; 1: random ready; 2: ready low 3 cycles at idx 1
  task automatic run_tree(input int a_s0, input int a_dn, input int a_ud, input int a_strike,
                          input int a_steps, input int mode);
    int  k, exp_idx, stall;
    bit  hold, fin, r;
    build_model(a_s0, a_dn, a_ud, a_steps);
    @(negedge clk);
    s0 = 12'(a_s0); dn_fac = 12'(a_dn); ud_ratio = 12'(a_ud);
    strike = 12'(a_strike); steps = 7'(a_steps); out_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 1; exp_idx = 0; stall = 0; hold = 0; fin = 0;
    chk("ovf_cleared", ovf, 0);
    while (!fin && k < 3000) begin
      chk("busy_run", busy, 1);
      if (exp_idx > 0 || hold) chk("valid_cont", out_valid, 1);
      if (out_valid) begin
        if (exp_idx == 0 && !hold) chk("latency", k, exp_n + 1);
        chk("data", out_data, payoff(exp_leaf[exp_idx], a_strike));
        chk("idx", out_idx, exp_idx);
        chk("last", out_last, exp_idx == exp_n);
        rx[exp_idx] = out_data;
        case (mode)
          1:       r = ($urandom_range(0, 3) != 0);
          2:       if (exp_idx == 1 && stall < 3) begin r = 0; stall++; end else r = 1;
          default: r = 1;
        endcase
        out_ready = r;
        if (r) begin
          if (exp_idx == exp_n) fin = 1;
          exp_idx++;
          hold = 0;
        end else begin
          hold = 1;
        end
      end
      @(negedge clk);
      k++;
    end
    out_ready = 1'b1;
    if (!fin) begin
      chk("timeout", 0, 1);
    end else begin
      chk("done_pulse", done, 1);
      chk("valid_after", out_valid, 0);
      chk("ovf_run", ovf, exp_ovf);
      @(negedge clk);
      chk("done_once", done, 0);
      chk("busy_idle", busy, 0);
      chk("ovf_sticky", ovf, exp_ovf);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; s0 = '0; dn_fac = '0; ud_ratio = '0;
    strike = '0; steps = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_last", out_last, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", ovf, 0);
    rst_n = 1'b1;

    run_tree(12'h100, 12'h008, 12'h040, 12'h0A0, 2, 0);
`ifdef FP12_LEAF_PAYOFF_EN
    chk("basic_l0", rx[0], 12'h000); chk("basic_l1", rx[1], 12'h060); chk("basic_l2", rx[2], 12'h360);
`else
    chk("basic_l0", rx[0], 12'h040); chk("basic_l1", rx[1], 12'h100); chk("basic_l2", rx[2], 12'h400);
`endif

    run_tree(12'h0A8, 12'h008, 12'h040, 12'h0A0, 0, 0);
`ifdef FP12_LEAF_PAYOFF_EN
    chk("steps0_l0", rx[0], 12'h008);
`else
    chk("steps0_l0", rx[0], 12'h0A8);
`endif

    run_tree(12'h018, 12'h009, 12'h010, 12'h000, 1, 0);
    chk("trunc_l0", rx[0], 12'h00D);
    chk("trunc_l1", rx[1], 12'h00D);

    run_tree(12'hC80, 12'h020, 12'h010, 12'h000, 1, 0);
    chk("ovf_l0", rx[0], 12'h900);
    chk("ovf_set", ovf, 1);

    run_tree(12'h100, 12'h008, 12'h040, 12'h0A0, 2, 2);
`ifdef FP12_LEAF_PAYOFF_EN
    chk("bp_l1", rx[1], 12'h060);
`else
    chk("bp_l1", rx[1], 12'h100);
`endif

    // reset in the middle of a stream
    @(negedge clk);
    s0 = 12'h100; dn_fac = 12'h008; ud_ratio = 12'h040; steps = 7'd2; out_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20 && !(out_valid && out_idx == 7'd1); i++) @(negedge clk);
    chk("mid_setup", out_valid && out_idx == 7'd1, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_idx", out_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_tree(12'h100, 12'h008, 12'h040, 12'h0A0, 2, 0);

    run_tree($urandom_range(0, 4095), $urandom_range(0, 4095), $urandom_range(0, 4095),
             $urandom_range(0, 4095), 100, 1);
    run_tree($urandom_range(0, 4095), 12'h010, 12'h010, $urandom_range(0, 4095), 64, 0);

    for (int t = 0; t < 25; t++) begin
      run_tree($urandom_range(0, 4095), $urandom_range(0, 48), $urandom_range(0, 48),
               $urandom_range(0, 4095), $urandom_range(0, 12), $urandom_range(0, 1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fp12_leaf_price_gen.md
Name: fp12_leaf_price_gen

Overview:
- Sequential generator of binomial-tree terminal (leaf) asset prices in unsigned 12-bit fixed point: 8 integer bits, 4 fractional bits.
- Sits directly upstream of the backward-induction stage, which multiplies leaf values by the risk-neutral weights.
- Computes leaf 0 = s0*dn^steps, then leaf j = leaf j-1 * ud_ratio. Uses one 12x12 fixed-point multiply per cycle.
- Streams leaves out over a valid/ready handshake.

Parameters:
- INT_LEN, 8, integer bits of the 12-bit fixed-point format; fractional bits = 12-INT_LEN.
- N_MAX_STEPS, 64, maximum tree depth; larger requests are clamped to this.
- STEP_W, 7, width of step/index fields; must hold N_MAX_STEPS.

Ports:
- clk, input, 1, single clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, request a new tree; accepted only in IDLE.
- s0, input, 12, spot price, 8.4 format.
- dn_fac, input, 12, down factor d, 8.4 format.
- ud_ratio, input, 12, u/d, 8.4 format.
- steps, input, STEP_W, tree depth N.
- strike, input, 12, strike price; used only with LEAF_PAYOFF_EN.
- busy, output, 1, high whenever state is not IDLE.
- out_valid, output, 1, leaf data valid.
- out_ready, input, 1, downstream accepts leaf.
- out_data, output, 12, leaf price (or payoff), 8.4 format.
- out_idx, output, STEP_W, leaf index j (number of up-moves).
- out_last, output, 1, high with the final leaf (j == steps).
- done, output, 1, one-cycle pulse after the last leaf handshake.
- ovf, output, 1, sticky overflow flag for the current run.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; internal accumulator, counters and latched operands 0.
- Multiply rule:
  - 24-bit product p = a*b; result = p[FRAC*2+INT_LEN-1 : FRAC], where FRAC = 12-INT_LEN. Default: p[15:4].
  - Truncating, no rounding.
  - Any nonzero bit above the result field sets ovf. ovf is sticky until the next accepted start.
- States: IDLE, DPOW, EMIT, DONE.
- IDLE:
  - On start=1: latch s0, dn_fac, ud_ratio, strike and steps_l = min(steps, N_MAX_STEPS).
  - Set acc<=s0, cnt<=steps_l, idx<=0, clear ovf.
  - Go to DPOW if steps_l>0, else to EMIT.
  - start in any other state is ignored.
- DPOW: acc<=mul(acc, dn_fac); cnt<=cnt-1; when cnt==1, go to EMIT.
- EMIT:
  - out_valid=1, out_data=f(acc), out_idx=idx, out_last=(idx==steps_l).
  - On out_valid&&out_ready with idx<steps_l: acc<=mul(acc, ud_ratio), idx<=idx+1, stay in EMIT. out_valid remains high, giving one leaf per cycle with ready held high.
  - On handshake with idx==steps_l: go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Latency: first out_valid is steps_l+1 cycles after the start cycle. steps=0 yields a single leaf s0 with out_last=1 at start+1.
- Backpressure: while out_valid && !out_ready, out_data, out_idx and out_last are held stable and acc does not update.
- All outputs are registered; total leaves per run = steps_l+1.
- Reset asserted mid-run: immediately returns to IDLE with all outputs 0. There is no partial stream resume.

Optional Feature:
- Macro: FP12_LEAF_PAYOFF_EN.
- Defined: out_data = (acc > strike) ? acc - strike : 0, i.e. the call payoff.
  - Computed from the registered acc in the same cycle.
  - Adds no latency.
- Undefined: out_data = acc. The strike port is present but ignored; no subtractor is synthesised.

Test Plan:
- Basic stream:
  - Stimulus: s0=0x100 (16.0), dn_fac=0x008 (0.5), ud_ratio=0x040 (4.0), steps=2, out_ready=1, start at cycle T.
  - Response: out_valid first at T+3; leaves 0x040, 0x100, 0x400 with idx 0,1,2; out_last on idx 2; done at T+6; ovf=0.
- steps=0:
  - Stimulus: s0=0x0A8.
  - Response: single leaf 0x0A8, idx 0, out_last=1 at T+1; done at T+2.
- Truncation:
  - Stimulus: s0=0x018 (1.5), dn_fac=0x009 (0.5625), steps=1, ud_ratio=0x010.
  - Response: leaf0=0x00D (0.8125), leaf1=0x00D.
- Overflow:
  - Stimulus: s0=0xC80 (200), dn_fac=0x020 (2.0), steps=1.
  - Response: leaf0=0x900; ovf=1, still 1 after done; cleared on next start.
- Backpressure and reset:
  - Stimulus: run the basic case with out_ready low 3 cycles at idx 1.
  - Response: out_data holds 0x100 the whole time.
  - Then assert rst_n=0 mid-stream: out_valid, busy and out_data are 0 immediately; a start after release begins fresh at idx 0.
- FP12_LEAF_PAYOFF_EN defined:
  - Stimulus: basic case with strike=0x0A0 (10.0).
  - Response: out_data 0x000, 0x060, 0x360.
